alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU.
- Operand width is configurable, and operands/results use valid/ready on both sides.
- Multiply is iterative (shift-add) and takes multiple cycles; status flags are registered.
- Sits between the operand-issue logic and the result consumer; the UVM agent drives the input side and monitors the output side.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), derived shift-amount width; do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift/rotate amount.
- op_code  in  4  operation select (alu_pkg::op_e).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- carry_out  out  1  carry/borrow/high-half-nonzero.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow.
- illegal  out  1  reserved opcode was issued.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: async, active-high. State=IDLE. result, all flags and out_valid = 0. Any in-flight multiply is discarded.
- Accept: a beat is taken when in_valid && in_ready. a, b and op_code are captured that edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready); combinational, no dependency on in_valid.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: accept of non-MUL -> HOLD; accept of MUL -> BUSY.
  - BUSY: counter loads WIDTH on accept and decrements each cycle; at 0 -> HOLD.
  - HOLD: out_valid=1.
    - out_ready && new accept: non-MUL -> HOLD with the new result; MUL -> BUSY.
    - out_ready && no accept -> IDLE.
    - !out_ready: stay in HOLD.
- Latency: non-MUL out_valid the cycle after accept (1). MUL out_valid WIDTH+1 cycles after accept.
- Throughput: non-MUL 1/cycle back-to-back while out_ready=1.
- Backpressure: in HOLD with out_ready=0, result and all flags hold stable and in_ready=0.
- Opcodes:
  - 0 ADD: carry = bit WIDTH; overflow = signed ovf.
  - 1 SUB: carry = borrow (a<b unsigned); overflow = signed ovf.
  - 2 MUL: result = low WIDTH bits of unsigned product; carry = overflow = |high half.
  - 3 AND, 4 OR, 5 XOR, 6 NOT (~a).
  - 7 SHL, 8 SHR (logical), 9 SRA, 10 ROL, 11 ROR: amount b[SHW-1:0], upper b bits ignored.
  - 12 EQ, 13 SLT (signed), 14 SLTU: result = {0...,cmp}.
  - 15 reserved: result=0, illegal=1, zero=1.
- carry/overflow = 0 wherever not listed above; illegal = 0 for opcodes 0-14.
- zero/negative are always computed from the final result.
- Flags are registered together with result in the same edge.
- Simultaneous out_ready and accept in HOLD: old beat retires and the new beat is captured in the same edge; no bubble for non-MUL.
- Reset asserted in BUSY/HOLD: immediate return to IDLE. The pending result is lost; no out_valid pulse.

Decomposition:
- alu_pkg:
  - op_e enum (4-bit, values above).
  - state_e {IDLE,BUSY,HOLD}.
  - alu_flags_t struct {carry,zero,negative,overflow,illegal}.
- Sub-module alu_mul_seq #(WIDTH):
  - start/done iterative shift-add unit; one partial-product step per cycle.
  - 2*WIDTH-bit product; done after WIDTH cycles.
  - Async-reset on reset.
- Top-level holds the FSM, single-cycle datapath, output register and handshake logic.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01 -> result 0x00, carry=1, zero=1, overflow=0; out_valid 1 cycle after accept.
- SUB a=0x80 b=0x01 -> 0x7F, overflow=1, carry=0, negative=0; SUB 0x00-0x01 -> 0xFF, carry=1, negative=1.
- MUL a=0x10 b=0x11 -> result 0x10, carry=1, overflow=1; out_valid 9 cycles after accept; in_ready=0 and busy=1 throughout.
- Back-to-back XOR/ROR/SRA with out_ready=1:
  - XOR 0xF0^0x3C -> 0xCC; ROR 0x81 by b=0x09 (amt 1) -> 0xC0; SRA 0x80 by 3 -> 0xF0.
  - One result per cycle, no bubbles.
- Backpressure: out_ready=0 for 3 cycles after ADD 0x05+0x03 -> result 0x08 held stable, in_ready=0; releasing out_ready with in_valid=1 retires 0x08 and accepts the next beat in the same edge.
- Reset asserted mid-MUL (cycle 4 of 8), then op 15 -> all outputs 0 asynchronously, no out_valid; after release op 15 gives result 0, illegal=1, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and FSM state encodings, and the
// status-flag bundle that is registered alongside every result.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SRA  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11,
        OP_EQ   = 4'd12,
        OP_SLT  = 4'd13,
        OP_SLTU = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle. The final
// step is presented combinationally on product while done is high, so the
// full 2*WIDTH-bit product is available exactly WIDTH cycles after start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [2*WIDTH-1:0] step_sum;

    assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = step_sum;
    assign done     = run_q && (cnt_q == (SHW+1)'(1));

    // Load operands on start, otherwise retire one multiplier bit per cycle.
    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = (SHW+1)'(WIDTH);
            run_d    = 1'b1;
        end else if (run_q) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - (SHW+1)'(1);
            if (cnt_q == (SHW+1)'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers; reset abandons any product in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath for all ops except MUL, which runs on
// the iterative multiplier. Result and flags are held in one output register
// until the consumer takes them; a new beat may be accepted on the same edge.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    alu_flags_t         flags_q, flags_d;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_ill;
    logic               load_alu;
    logic               load_mul;

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_e'(op_code) == OP_MUL);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: result plus the op-specific carry/overflow/illegal.
    always_comb begin
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [WIDTH:0]          sum;
        logic [WIDTH:0]          diff;
        logic [SHW-1:0]          amt;
        logic [SHW:0]            inv_amt;

        a_s       = a;
        b_s       = b;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        amt       = b[SHW-1:0];
        inv_amt   = (SHW+1)'(WIDTH) - {1'b0, amt};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (op_e'(op_code))
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:  alu_res = '0;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL:  alu_res = a << amt;
            OP_SHR:  alu_res = a >> amt;
            OP_SRA:  alu_res = $unsigned(a_s >>> amt);
            OP_ROL:  alu_res = (a << amt) | (a >> inv_amt);
            OP_ROR:  alu_res = (a >> amt) | (a << inv_amt);
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a == b};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, a_s < b_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            default: alu_ill = 1'b1;
        endcase
    end

    // FSM next state and output-register load selection.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        flags_d  = flags_q;
        load_alu = 1'b0;
        load_mul = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = is_mul ? BUSY : HOLD;
                    load_alu = !is_mul;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d  = HOLD;
                    load_mul = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d  = is_mul ? BUSY : HOLD;
                        load_alu = !is_mul;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_alu) begin
            res_d            = alu_res;
            flags_d.carry    = alu_carry;
            flags_d.overflow = alu_ovf;
            flags_d.illegal  = alu_ill;
            flags_d.zero     = ~|alu_res;
            flags_d.negative = alu_res[WIDTH-1];
        end else if (load_mul) begin
            res_d            = mul_product[WIDTH-1:0];
            flags_d.carry    = |mul_product[2*WIDTH-1:WIDTH];
            flags_d.overflow = |mul_product[2*WIDTH-1:WIDTH];
            flags_d.illegal  = 1'b0;
            flags_d.zero     = ~|mul_product[WIDTH-1:0];
            flags_d.negative = mul_product[WIDTH-1];
        end
    end

    // State, result and flags registered together on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign result    = res_q;
    assign carry_out = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign overflow  = flags_q.overflow;
    assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed beats from the test plan followed by
// random beats with random backpressure, all checked against an arithmetic
// reference model by a single per-cycle compare process.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op_code = '0;
    logic         in_ready, out_valid, carry_out, zero, negative, overflow, illegal, busy;
    logic [W-1:0] result;

    // Optional hand-computed expectation travelling with the current beat.
    logic         lit_en = 1'b0;
    logic [W-1:0] lit_res = '0;
    logic [4:0]   lit_flags = '0;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   fl;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint m   = longint'(1) << W;
        longint ua  = longint'(av);
        longint ub  = longint'(bv);
        longint sa  = (ua >= m / 2) ? ua - m : ua;
        longint sb  = (ub >= m / 2) ? ub - m : ub;
        longint amt = ub % W;
        longint r   = 0;
        logic   c   = 1'b0;
        logic   v   = 1'b0;
        logic   il  = 1'b0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r >= m); v = ((sa + sb) >= m / 2) || ((sa + sb) < -(m / 2)); end
            4'd1:  begin r = ua - ub; c = (ua < ub); v = ((sa - sb) >= m / 2) || ((sa - sb) < -(m / 2)); end
            4'd2:  begin r = ua * ub; c = (r >= m); v = c; end
            4'd3:  r = longint'(av & bv);
            4'd4:  r = longint'(av | bv);
            4'd5:  r = longint'(av ^ bv);
            4'd6:  r = m - 1 - ua;
            4'd7:  r = ua << amt;
            4'd8:  r = ua >> amt;
            4'd9:  r = sa >>> amt;
            4'd10: r = (ua << amt) | (ua >> (W - amt));
            4'd11: r = (ua >> amt) | (ua << (W - amt));
            4'd12: r = longint'(ua == ub);
            4'd13: r = longint'(sa < sb);
            4'd14: r = longint'(ua < ub);
            default: begin r = 0; il = 1'b1; end
        endcase
        r = ((r % m) + m) % m;
        e.res = r[W-1:0];
        e.fl  = {c, (r == 0), (r >= m / 2), v, il};
        e.lat = (op == 4'd2) ? W + 1 : 1;
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, req);
        end
    endtask

    // Compare process: one evaluation per falling edge.
    initial begin
        exp_t e;
        logic head_valid;
        logic exp_ir;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                q.delete();
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_result", 32'(result), 32'd0);
                chk("rst_flags", 32'({carry_out, zero, negative, overflow, illegal}), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
            end else begin
                head_valid = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
                exp_ir = (q.size() == 0) ? 1'b1 : (head_valid ? out_ready : 1'b0);
                chk("out_valid", 32'(out_valid), 32'(head_valid));
                chk("busy", 32'(busy), 32'(q.size() > 0));
                chk("in_ready", 32'(in_ready), 32'(exp_ir));
                if (head_valid) begin
                    chk("result", 32'(result), 32'(q[0].res));
                    chk("flags", 32'({carry_out, zero, negative, overflow, illegal}), 32'(q[0].fl));
                    if (out_ready) void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    e = model(op_code, a, b);
                    e.acc = cyc;
                    if (lit_en) begin
                        chk("model_res", 32'(e.res), 32'(lit_res));
                        chk("model_flags", 32'(e.fl), 32'(lit_flags));
                    end
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic le, input logic [W-1:0] lr, input logic [4:0] lf);
        in_valid  = 1'b1;
        op_code   = op;
        a         = av;
        b         = bv;
        lit_en    = le;
        lit_res   = lr;
        lit_flags = lf;
    endtask

    task automatic wait_accept(input logic rand_rdy);
        int   k = 0;
        logic took = 1'b0;
        do begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            took = in_ready;
            @(posedge clock);
            #1;
            k++;
        end while (!took && k < 64);
        if (!took) begin
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
            $fatal(1, "accept timeout");
        end
    endtask

    task automatic beat(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic le, input logic [W-1:0] lr, input logic [4:0] lf);
        drive(op, av, bv, le, lr, lf);
        wait_accept(1'b0);
    endtask

    task automatic idle(input int n, input logic rand_rdy);
        in_valid = 1'b0;
        lit_en   = 1'b0;
        repeat (n) begin
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
        end
    endtask

    // Stimulus: flags literal order is {carry, zero, negative, overflow, illegal}.
    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        beat(4'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 5'b11000);
        idle(2, 1'b0);
        beat(4'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 5'b00010);
        beat(4'd1, 8'h00, 8'h01, 1'b1, 8'hFF, 5'b10100);
        idle(1, 1'b0);
        beat(4'd2, 8'h10, 8'h11, 1'b1, 8'h10, 5'b10010);
        idle(12, 1'b0);

        beat(4'd5,  8'hF0, 8'h3C, 1'b1, 8'hCC, 5'b00100);
        beat(4'd11, 8'h81, 8'h09, 1'b1, 8'hC0, 5'b00100);
        beat(4'd9,  8'h80, 8'h03, 1'b1, 8'hF0, 5'b00100);
        idle(2, 1'b0);

        out_ready = 1'b0;
        beat(4'd0, 8'h05, 8'h03, 1'b1, 8'h08, 5'b00000);
        drive(4'd3, 8'hFF, 8'h0F, 1'b1, 8'h0F, 5'b00000);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        wait_accept(1'b0);
        idle(2, 1'b0);

        beat(4'd2, 8'hAB, 8'hCD, 1'b0, 8'h00, 5'b00000);
        idle(4, 1'b0);
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
        beat(4'd15, 8'h12, 8'h34, 1'b1, 8'h00, 5'b01001);
        beat(4'd10, 8'h81, 8'h01, 1'b1, 8'h03, 5'b00000);
        beat(4'd14, 8'h01, 8'hFF, 1'b1, 8'h01, 5'b00000);
        beat(4'd13, 8'h01, 8'hFF, 1'b1, 8'h00, 5'b01000);
        idle(2, 1'b0);

        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'b0, 8'h00, 5'b00000);
            wait_accept(1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
        end

        out_ready = 1'b1;
        idle(15, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
